oq_packet_scheduler: RTL and testbench
======================================

Name: oq_packet_scheduler

Overview:
- Packet-granular round-robin scheduler that merges NUM_QUEUES AXI4-Stream output-queue channels onto one egress AXI4-Stream port.
- Sits downstream of the BRAM output queues when several queues share one physical MAC or DMA channel.
- Never interleaves beats of different packets.
- Reports per-packet completion (queue index and byte count) for the statistics counters in the register block.

Parameters:
C_AXIS_DATA_WIDTH, 256, tdata width for all streams; tstrb width is C_AXIS_DATA_WIDTH/8.
C_AXIS_TUSER_WIDTH, 128, tuser width for all streams.
NUM_QUEUES, 5, number of input queues (2..16).
QIDX_W, 4, width of the queue index outputs; must satisfy 2^QIDX_W >= NUM_QUEUES.

Ports:
axi_aclk  in  1  clock
axi_resetn  in  1  asynchronous active-low reset
s_axis_tdata  in  NUM_QUEUES*C_AXIS_DATA_WIDTH  per-queue data; queue i occupies slice i
s_axis_tstrb  in  NUM_QUEUES*C_AXIS_DATA_WIDTH/8  per-queue byte strobes
s_axis_tuser  in  NUM_QUEUES*C_AXIS_TUSER_WIDTH  per-queue sideband
s_axis_tvalid  in  NUM_QUEUES  per-queue valid
s_axis_tlast  in  NUM_QUEUES  per-queue last
s_axis_tready  out  NUM_QUEUES  per-queue ready
m_axis_tdata  out  C_AXIS_DATA_WIDTH  egress data
m_axis_tstrb  out  C_AXIS_DATA_WIDTH/8  egress strobes
m_axis_tuser  out  C_AXIS_TUSER_WIDTH  egress sideband
m_axis_tvalid  out  1  egress valid
m_axis_tlast  out  1  egress last
m_axis_tready  in  1  egress ready
cur_queue  out  QIDX_W  queue currently granted
pkt_sent  out  1  one-cycle pulse on packet completion
pkt_sent_queue  out  QIDX_W  queue of the completed packet; valid with pkt_sent
pkt_sent_bytes  out  32  byte count of the completed packet; valid with pkt_sent

Behaviour:
- Reset (asynchronous, axi_resetn=0):
  - state=IDLE, last_grant=NUM_QUEUES-1 (queue 0 is served first), cur_queue=0, byte accumulator=0.
  - pkt_sent=0, pkt_sent_queue=0, pkt_sent_bytes=0.
  - All s_axis_tready=0, m_axis_tvalid=0.
- Reset asserted mid-packet: the packet is abandoned and no pkt_sent pulse is produced. The upstream queue keeps its remaining beats; after reset they are forwarded as a new packet.
- State machine, two states:
  - IDLE: scan queues last_grant+1, +2, ... (wrapping modulo NUM_QUEUES) for the first one with tvalid=1. If found, register the grant into cur_queue, clear the accumulator, go to SEND. If none, stay in IDLE. All outputs are idle in IDLE: m_axis_tvalid=0, every s_axis_tready=0.
  - SEND: combinational pass-through from cur_queue.
    - m_axis_tdata/tstrb/tuser/tlast/tvalid = slice cur_queue.
    - s_axis_tready[cur_queue] = m_axis_tready; every other tready=0.
    - Each accepted beat (tvalid&tready) adds popcount(tstrb) to the 32-bit accumulator. The accumulator wraps modulo 2^32.
    - An accepted beat with tlast=1 sets last_grant=cur_queue and returns to IDLE.
- Timing:
  - Arbitration costs exactly one idle cycle between packets.
  - First beat of a packet is forwarded in the cycle after IDLE observes tvalid.
- Completion reporting:
  - pkt_sent is registered and pulses high one cycle after the accepted tlast beat.
  - pkt_sent_bytes includes the last beat's strobes; pkt_sent_queue equals the finishing queue.
- Fairness: a queue that stays valid waits at most NUM_QUEUES-1 packets.
- Handshake rules:
  - Egress backpressure (m_axis_tready=0) stalls only the granted queue.
  - tvalid dropping mid-packet leaves the grant held with no timeout.
  - A single-beat packet (tlast on first beat) is legal.
  - Simultaneous tvalid on all queues resolves purely by rotation from last_grant.
  - A tvalid rise during the IDLE arbitration cycle on a lower-priority queue does not preempt the chosen queue.

Optional Feature:
STRICT_PRIO_Q0_EN
- Defined: in IDLE, queue 0 wins whenever s_axis_tvalid[0]=1, regardless of last_grant. The other queues round-robin among themselves, and last_grant updates only for queues 1..NUM_QUEUES-1. A packet already in SEND is never preempted.
- Undefined: plain round-robin over all queues as described above.

Test Plan:
- Reset, then queue 2 sends one 3-beat packet with all tstrb=0xFFFFFFFF, the last beat tstrb=0x0000FFFF → egress shows 3 beats after one idle cycle; pkt_sent pulses once with queue=2, bytes=80.
- Queues 0..4 all hold 2-beat packets continuously, m_axis_tready=1 → grant order 0,1,2,3,4,0,...; exactly one idle cycle between packets; no beat interleaving.
- Queue 1 mid-packet with m_axis_tready toggling 1010 → queue 1 stalls in lockstep; other queues' tready stays 0 throughout; the byte count matches the accepted beats only.
- Queue 3 sending, deassert axi_resetn for one cycle mid-packet → all outputs 0 immediately; no pkt_sent pulse; the next grant goes to the lowest-indexed valid queue.
- STRICT_PRIO_Q0_EN defined, queues 0 and 4 continuously valid → queue 0 served for every packet and queue 4 starves. Same stimulus without the macro → strict alternation 0,4,0,4.

Source files
------------

// File: rtl/oq_packet_scheduler.sv
// oq_packet_scheduler: packet-granular round-robin merge of NUM_QUEUES AXI4-Stream queues onto one egress port.
// Optional macro STRICT_PRIO_Q0_EN: queue 0 wins every arbitration in which it is valid.
module oq_packet_scheduler #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int NUM_QUEUES         = 5,
    parameter int QIDX_W             = 4
) (
    input  logic                                     axi_aclk,
    input  logic                                     axi_resetn,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic [NUM_QUEUES*C_AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic [NUM_QUEUES*C_AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [NUM_QUEUES-1:0]                    s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                    s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                    s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]           m_axis_tstrb,
    output logic [C_AXIS_TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                                     m_axis_tvalid,
    output logic                                     m_axis_tlast,
    input  logic                                     m_axis_tready,
    output logic [QIDX_W-1:0]                        cur_queue,
    output logic                                     pkt_sent,
    output logic [QIDX_W-1:0]                        pkt_sent_queue,
    output logic [31:0]                              pkt_sent_bytes
);
    localparam int STRB_W = C_AXIS_DATA_WIDTH/8;

    typedef enum logic {IDLE, SEND} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [QIDX_W-1:0] r_last_grant;
    logic [QIDX_W-1:0] r_cur_queue;
    logic [31:0]       r_acc;
    logic              r_pkt_sent;
    logic [QIDX_W-1:0] r_pkt_sent_queue;
    logic [31:0]       r_pkt_sent_bytes;
    logic              w_found;
    logic [QIDX_W-1:0] w_grant;
    logic              w_beat;
    logic [31:0]       w_beat_bytes;

    function automatic logic [31:0] popcount(input logic [STRB_W-1:0] strb);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < STRB_W; i++) begin
            n = n + {31'd0, strb[i]};
        end
        return n;
    endfunction

    // Rotating search starting just after the last finished queue; constant
    // bit indices keep the search a plain priority mux.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_grant = '0;
`ifdef STRICT_PRIO_Q0_EN
        if (s_axis_tvalid[0]) begin
            w_found = 1'b1;
        end
`endif
        for (int k = 1; k <= NUM_QUEUES; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_QUEUES;
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (!w_found && idx == i && s_axis_tvalid[i]) begin
                    w_found = 1'b1;
                    w_grant = QIDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tstrb  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (r_state == SEND) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                if (r_cur_queue == QIDX_W'(i)) begin
                    m_axis_tdata     = s_axis_tdata[i*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
                    m_axis_tstrb     = s_axis_tstrb[i*STRB_W +: STRB_W];
                    m_axis_tuser     = s_axis_tuser[i*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
                    m_axis_tvalid    = s_axis_tvalid[i];
                    m_axis_tlast     = s_axis_tlast[i];
                    s_axis_tready[i] = m_axis_tready;
                end
            end
        end
    end

    assign w_beat       = m_axis_tvalid & m_axis_tready;
    assign w_beat_bytes = popcount(m_axis_tstrb);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_nxt = SEND;
            SEND:    if (w_beat && m_axis_tlast) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_state          <= IDLE;
            r_last_grant     <= QIDX_W'(NUM_QUEUES-1);
            r_cur_queue      <= '0;
            r_acc            <= '0;
            r_pkt_sent       <= 1'b0;
            r_pkt_sent_queue <= '0;
            r_pkt_sent_bytes <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pkt_sent <= 1'b0;
            if (r_state == IDLE && w_found) begin
                r_cur_queue <= w_grant;
                r_acc       <= '0;
            end
            if (w_beat) begin
                r_acc <= r_acc + w_beat_bytes;
                if (m_axis_tlast) begin
                    r_pkt_sent       <= 1'b1;
                    r_pkt_sent_queue <= r_cur_queue;
                    r_pkt_sent_bytes <= r_acc + w_beat_bytes;
`ifdef STRICT_PRIO_Q0_EN
                    // Queue 0 sits outside the rotation, so it never moves the pointer.
                    if (r_cur_queue != '0) begin
                        r_last_grant <= r_cur_queue;
                    end
`else
                    r_last_grant <= r_cur_queue;
`endif
                end
            end
        end
    end

    assign cur_queue      = r_cur_queue;
    assign pkt_sent       = r_pkt_sent;
    assign pkt_sent_queue = r_pkt_sent_queue;
    assign pkt_sent_bytes = r_pkt_sent_bytes;

endmodule

// File: tb/tb_oq_packet_scheduler.sv
// Bench for oq_packet_scheduler: queue-based sources, packet-level reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_oq_packet_scheduler;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NQ = 5;
    localparam int QW = 4;
    localparam int SW = DW/8;

    logic              clk = 1'b0;
    logic              axi_resetn;
    logic [NQ*DW-1:0]  s_axis_tdata;
    logic [NQ*SW-1:0]  s_axis_tstrb;
    logic [NQ*UW-1:0]  s_axis_tuser;
    logic [NQ-1:0]     s_axis_tvalid;
    logic [NQ-1:0]     s_axis_tlast;
    logic [NQ-1:0]     s_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [SW-1:0]     m_axis_tstrb;
    logic [UW-1:0]     m_axis_tuser;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [QW-1:0]     cur_queue;
    logic              pkt_sent;
    logic [QW-1:0]     pkt_sent_queue;
    logic [31:0]       pkt_sent_bytes;

    always #5 clk = ~clk;

    oq_packet_scheduler #(
        .C_AXIS_DATA_WIDTH (DW),
        .C_AXIS_TUSER_WIDTH(UW),
        .NUM_QUEUES        (NQ),
        .QIDX_W            (QW)
    ) dut (
        .axi_aclk      (clk),
        .axi_resetn    (axi_resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .cur_queue     (cur_queue),
        .pkt_sent      (pkt_sent),
        .pkt_sent_queue(pkt_sent_queue),
        .pkt_sent_bytes(pkt_sent_bytes)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    beat_t       srcq [NQ][$];
    logic [NQ-1:0] vld;

    int checks = 0;
    int errors = 0;

    // Reference model state: who owns the egress, where the rotation resumes, running byte count.
    int          owner;
    int          last_served;
    int          cur_exp;
    logic [31:0] acc;
    logic        exp_pulse;
    int          exp_pq;
    logic [31:0] exp_pb;
    int          mdl_order[$];
    int          mdl_bytes[$];
    int          dut_order[$];
    int          dut_bytes[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic int arb(input logic [NQ-1:0] v);
`ifdef STRICT_PRIO_Q0_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= NQ; k++) begin
            if (v[(last_served + k) % NQ]) return (last_served + k) % NQ;
        end
        return -1;
    endfunction

    function automatic bit busy();
        if (owner >= 0 || exp_pulse) return 1'b1;
        for (int i = 0; i < NQ; i++) if (srcq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        owner = -1; last_served = NQ-1; cur_exp = 0; acc = '0;
        exp_pulse = 1'b0; exp_pq = 0; exp_pb = '0;
    endtask

    task automatic push_beat(input int q, input logic [SW-1:0] strb, input logic last);
        beat_t b;
        b.data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        b.user = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.strb = strb;
        b.last = last;
        srcq[q].push_back(b);
    endtask

    task automatic drive_sources();
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0; vld = '0;
        for (int i = 0; i < NQ; i++) begin
            if (srcq[i].size() > 0) begin
                vld[i] = 1'b1;
                s_axis_tdata[i*DW +: DW] = srcq[i][0].data;
                s_axis_tstrb[i*SW +: SW] = srcq[i][0].strb;
                s_axis_tuser[i*UW +: UW] = srcq[i][0].user;
                s_axis_tvalid[i]         = 1'b1;
                s_axis_tlast[i]          = srcq[i][0].last;
            end
        end
    endtask

    task automatic compare();
        logic [NQ-1:0] exp_rdy;
        logic          exp_v;
        exp_rdy = '0;
        exp_v   = 1'b0;
        if (owner >= 0) begin
            exp_v          = vld[owner];
            exp_rdy[owner] = m_axis_tready;
        end
        chk("m_tvalid", m_axis_tvalid, exp_v);
        chk("s_tready", s_axis_tready, exp_rdy);
        chk("cur_queue", cur_queue, cur_exp);
        chk("pkt_sent", pkt_sent, exp_pulse);
        chk("pkt_sent_queue", pkt_sent_queue, exp_pq);
        chk("pkt_sent_bytes", pkt_sent_bytes, exp_pb);
        if (exp_v) begin
            chk("m_tdata", m_axis_tdata, srcq[owner][0].data);
            chk("m_tstrb", m_axis_tstrb, srcq[owner][0].strb);
            chk("m_tuser", m_axis_tuser, srcq[owner][0].user);
            chk("m_tlast", m_axis_tlast, srcq[owner][0].last);
        end
        if (pkt_sent === 1'b1) begin
            dut_order.push_back(int'(pkt_sent_queue));
            dut_bytes.push_back(int'(pkt_sent_bytes));
        end
    endtask

    task automatic model_update(input logic mr);
        exp_pulse = 1'b0;
        if (owner < 0) begin
            int p;
            p = arb(vld);
            if (p >= 0) begin
                owner = p; cur_exp = p; acc = '0;
            end
        end else if (vld[owner] && mr) begin
            acc = acc + 32'($countones(srcq[owner][0].strb));
            if (srcq[owner][0].last) begin
                exp_pulse = 1'b1; exp_pq = owner; exp_pb = acc;
                mdl_order.push_back(owner);
                mdl_bytes.push_back(int'(acc));
`ifdef STRICT_PRIO_Q0_EN
                if (owner != 0) last_served = owner;
`else
                last_served = owner;
`endif
                owner = -1;
            end
        end
    endtask

    task automatic step(input logic mr, input logic rst);
        logic [NQ-1:0] fire;
        @(negedge clk);
        axi_resetn    = ~rst;
        m_axis_tready = mr;
        drive_sources();
        #1;
        if (rst) model_reset();
        compare();
        fire = s_axis_tvalid & s_axis_tready;
        @(posedge clk);
        if (!rst) model_update(mr);
        for (int i = 0; i < NQ; i++) if (fire[i]) srcq[i].delete(0);
    endtask

    // pat 0: egress always ready; pat 1: egress ready toggles 1,0,1,0...
    task automatic run(input int maxc, input int pat);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            step((pat == 1) ? ((n % 2) == 0) : 1'b1, 1'b0);
            n++;
        end
        if (busy()) begin
            checks++; errors++;
            $display("FAIL run_timeout: still busy after %0d cycles, required idle", maxc);
            for (int i = 0; i < NQ; i++) srcq[i].delete();
            owner = -1; exp_pulse = 1'b0;
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
    endtask

    task automatic reset_dut();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        mdl_order.delete(); mdl_bytes.delete();
        dut_order.delete(); dut_bytes.delete();
    endtask

    task automatic check_log(input string name, input int eq[$], input int eb[$]);
        chk({name, "_mdl_count"}, mdl_order.size(), eq.size());
        chk({name, "_dut_count"}, dut_order.size(), eq.size());
        for (int i = 0; i < eq.size(); i++) begin
            chk({name, "_mdl_queue"}, qget(mdl_order, i), eq[i]);
            chk({name, "_mdl_bytes"}, qget(mdl_bytes, i), eb[i]);
            chk({name, "_dut_queue"}, qget(dut_order, i), eq[i]);
            chk({name, "_dut_bytes"}, qget(dut_bytes, i), eb[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_resetn = 1'b0; m_axis_tready = 1'b0;
        s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
        s_axis_tvalid = '0; s_axis_tlast = '0; vld = '0;
        model_reset();

        // Reset state, then one 3-beat packet on queue 2: 32+32+16 bytes.
        reset_dut();
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_pkt_bytes", pkt_sent_bytes, 32'd0);
        push_beat(2, 32'hFFFF_FFFF, 1'b0);
        push_beat(2, 32'hFFFF_FFFF, 1'b0);
        push_beat(2, 32'h0000_FFFF, 1'b1);
        run(100, 0);
        check_log("t1", '{2}, '{80});

        // All five queues hold two 2-beat packets: plain rotation from queue 0.
        reset_dut();
        for (int p = 0; p < 2; p++)
            for (int q = 0; q < NQ; q++) begin
                push_beat(q, 32'hFFFF_FFFF, 1'b0);
                push_beat(q, 32'hFFFF_FFFF, 1'b1);
            end
        run(200, 0);
        check_log("t2", '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4}, '{64, 64, 64, 64, 64, 64, 64, 64, 64, 64});

        // Queue 1 under toggling backpressure while queue 3 waits: 32+8+4 bytes, then 1 byte.
        reset_dut();
        push_beat(1, 32'hFFFF_FFFF, 1'b0);
        push_beat(1, 32'h0000_00FF, 1'b0);
        push_beat(1, 32'h0000_000F, 1'b1);
        push_beat(3, 32'h0000_0001, 1'b1);
        run(100, 1);
        check_log("t3", '{1, 3}, '{44, 1});

        // Reset in the middle of a queue 3 packet: abandoned, remaining two beats resent later.
        reset_dut();
        for (int b = 0; b < 4; b++) push_beat(3, 32'hFFFF_FFFF, b == 3);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        push_beat(1, 32'h0000_000F, 1'b1);
        step(1'b1, 1'b1);
        chk("midrst_m_tvalid", m_axis_tvalid, 1'b0);
        chk("midrst_s_tready", s_axis_tready, '0);
        chk("midrst_pkt_sent", pkt_sent, 1'b0);
        run(100, 0);
        check_log("t4", '{1, 3}, '{4, 64});

        // Queues 0 and 4 continuously valid with single-beat packets.
        reset_dut();
        for (int p = 0; p < 3; p++) begin
            push_beat(0, 32'hFFFF_FFFF, 1'b1);
            push_beat(4, 32'hFFFF_FFFF, 1'b1);
        end
        run(100, 0);
`ifdef STRICT_PRIO_Q0_EN
        check_log("t5", '{0, 0, 0, 4, 4, 4}, '{32, 32, 32, 32, 32, 32});
`else
        check_log("t5", '{0, 4, 0, 4, 0, 4}, '{32, 32, 32, 32, 32, 32});
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
